// File: rtl/instr_fetch.sv
// RV32I instruction fetch front end: owns the PC, issues credit-limited imem requests and
// buffers in-order responses for the decoder. Optional build macro: FETCH_MISALIGN_CHECK_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [6:0]  op_code,
    output logic [2:0]  func3,
    output logic [6:0]  func7,
    output logic        fetch_fault
);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W + 1)'(BUF_DEPTH);

    typedef enum logic {ST_FETCH, ST_FAULT} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [31:0]      r_fetch_pc;
    logic [31:0]      r_rsp_pc;
    logic [31:0]      r_buf_data [BUF_DEPTH];
    logic [31:0]      r_buf_pc   [BUF_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_drop_cnt;
    logic             r_fetch_fault;

    logic [31:0]      w_redirect_pc;
    logic             w_misaligned;
    logic             w_req_fire;
    logic             w_rsp_take;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W:0]   w_occupancy;
    logic [31:0]      w_head_data;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign w_redirect_pc = redirect_pc;
    assign w_misaligned  = redirect_valid & (redirect_pc[1:0] != 2'b00);
`else
    logic [1:0] w_unused_pc_lsb;
    assign w_unused_pc_lsb = redirect_pc[1:0];
    assign w_redirect_pc   = {redirect_pc[31:2], 2'b00};
    assign w_misaligned    = 1'b0;
`endif

    // Credits cover both buffered words and words still in flight, so a response
    // can never arrive to a full buffer.
    assign w_occupancy    = {1'b0, r_count} + {1'b0, r_outstanding};
    assign imem_req_valid = rst_n & (r_state == ST_FETCH) & ~redirect_valid
                          & (w_occupancy < DEPTH_EXT);
    assign imem_req_addr  = r_fetch_pc;

    assign w_req_fire = imem_req_valid & imem_req_ready;
    assign w_rsp_take = imem_rsp_valid & (r_outstanding != '0);
    assign w_push     = w_rsp_take & (r_drop_cnt == '0) & ~redirect_valid;
    assign w_pop      = instr_valid & instr_ready;

    assign w_head_data = r_buf_data[r_rd_ptr];
    assign instr_valid = rst_n & (r_count != '0);
    assign instr       = w_head_data;
    assign instr_pc    = r_buf_pc[r_rd_ptr];
    assign op_code     = w_head_data[6:0];
    assign func3       = w_head_data[14:12];
    assign func7       = w_head_data[31:25];
    assign fetch_fault = r_fetch_fault;

    always_comb begin
        // NOTE: default first so every path assigns the target and no latch is inferred.
        w_state_next = r_state;
        if ((r_state == ST_FETCH) && w_misaligned) begin
            w_state_next = ST_FAULT;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_FETCH;
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_fetch_fault <= 1'b0;
            // NOTE: the buffer storage is reset because the decoder-facing fields must
            // read as zero straight out of reset; it is only BUF_DEPTH entries.
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_buf_data[i] <= '0;
                r_buf_pc[i]   <= '0;
            end
        end else begin
            r_state       <= w_state_next;
            r_outstanding <= r_outstanding + CNT_W'(w_req_fire) - CNT_W'(w_rsp_take);
            if (w_misaligned) begin
                r_fetch_fault <= 1'b1;
            end
            if (redirect_valid) begin
                // Every word still in flight after this edge belongs to the old path.
                r_drop_cnt <= r_outstanding - CNT_W'(w_rsp_take);
                r_fetch_pc <= w_redirect_pc;
                r_rsp_pc   <= w_redirect_pc;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_rsp_take && (r_drop_cnt != '0)) begin
                    r_drop_cnt <= r_drop_cnt - CNT_W'(1);
                end
                if (w_push) begin
                    r_buf_data[r_wr_ptr] <= imem_rsp_data;
                    r_buf_pc[r_wr_ptr]   <= r_rsp_pc;
                    r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
                    r_rsp_pc             <= r_rsp_pc + 32'd4;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end
    end
endmodule
